// File: rtl/console_fs_gen_pkg.sv
// ============================================================================
// console_pkg : shared types and rate-table helpers for the fs strobe generator
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package console_pkg;

    localparam int         FREQ_W       = 4;
    localparam logic [3:0] RATE_DEFAULT = 4'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_WORK = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Code k runs at base_rate << (k-1)
    function automatic int fs_divisor(input int clk_freq, input int base_rate, input int code);
        return clk_freq / (base_rate << (code - 1));
    endfunction

    function automatic logic [3:0] rate_map(input logic [3:0] code, input int num_rates);
        if (code == 4'd0 || int'(code) > num_rates) begin
            return RATE_DEFAULT;
        end
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/console_fs_gen_if.sv
// ============================================================================
// console_fs_gen_if : control/acquisition-side signal bundle of console_fs_gen
// Revision          : 1.0  initial release
// ============================================================================
`default_nettype none

interface console_fs_gen_if #(
    parameter int ERR_W = 8
);
    logic [console_pkg::FREQ_W-1:0] freq_samp;
    logic                           fs_en;
    logic                           fd;
    logic                           fs;
    logic                           miss;
    logic [ERR_W-1:0]               miss_cnt;
    logic [console_pkg::FREQ_W-1:0] rate_cur;
    logic                           busy;

    modport slave (
        input  freq_samp, fs_en, fd,
        output fs, miss, miss_cnt, rate_cur, busy
    );

    modport master (
        output freq_samp, fs_en, fd,
        input  fs, miss, miss_cnt, rate_cur, busy
    );
endinterface

`default_nettype wire

// File: rtl/console_fs_gen_period_cnt.sv
// ============================================================================
// console_period_cnt : free-running period counter, divisor reloaded on wrap
// Revision           : 1.0  initial release
// ============================================================================
`default_nettype none

module console_period_cnt #(
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] DIV_RST = '1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clear,
    input  wire logic             i_run,
    input  wire logic             i_track,
    input  wire logic [CNT_W-1:0] i_div_next,
    output logic                  o_wrap
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic             w_wrap;

    assign w_wrap = i_run && (r_cnt == r_div - 1'b1);
    assign o_wrap = w_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_div <= DIV_RST;
        end else begin
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_run) begin
                r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            end
            // Reloading only on wrap keeps every period whole across rate changes
            if (i_track || w_wrap) begin
                r_div <= i_div_next;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/console_fs_gen.sv
// ============================================================================
// console_fs_gen : periodic fs request with fd handshake, ack timeout and
//                  saturating missed-sample accounting
// Revision       : 1.0  initial release
// ============================================================================
`default_nettype none

module console_fs_gen
    import console_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BASE_RATE   = 1_000,
    parameter int NUM_RATES   = 5,
    parameter int CNT_W       = 16,
    parameter int ACK_TIMEOUT = 128,
    parameter int ERR_W       = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    console_fs_gen_if.slave  bus
);

    localparam int               ACK_W      = $clog2(ACK_TIMEOUT + 1);
    localparam logic [ACK_W-1:0] c_ack_last = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_div_rst  = CNT_W'(fs_divisor(CLK_FREQ, BASE_RATE, 1));

    state_t            r_state;
    logic              r_fs;
    logic              r_busy;
    logic              r_miss;
    logic [ERR_W-1:0]  r_miss_cnt;
    logic [ACK_W-1:0]  r_ack;
    logic [FREQ_W-1:0] r_rate;

    logic [FREQ_W-1:0] w_code_req;
    logic [CNT_W-1:0]  w_div_tab [16];
    logic [CNT_W-1:0]  w_div_next;
    logic              w_clear;
    logic              w_run;
    logic              w_track;
    logic              w_wrap;

    for (genvar k = 0; k < 16; k++) begin : g_div_tab
        assign w_div_tab[k] = CNT_W'(fs_divisor(CLK_FREQ, BASE_RATE,
                                                int'(rate_map(4'(k), NUM_RATES))));
    end

    for (genvar k = 1; k <= NUM_RATES; k++) begin : g_div_chk
        if (fs_divisor(CLK_FREQ, BASE_RATE, k) >= (1 << CNT_W)) begin : g_too_big
            $error("console_fs_gen: divisor for code %0d does not fit CNT_W", k);
        end
        if (fs_divisor(CLK_FREQ, BASE_RATE, k) <= ACK_TIMEOUT + 2) begin : g_too_small
            $error("console_fs_gen: divisor for code %0d not above ACK_TIMEOUT+2", k);
        end
    end

    assign w_code_req = rate_map(bus.freq_samp, NUM_RATES);
    assign w_div_next = w_div_tab[w_code_req];
    assign w_clear    = (r_state == ST_IDLE) || (r_state == ST_WAIT);
    assign w_track    = (r_state == ST_WAIT);
    assign w_run      = (r_state == ST_WORK) || (r_state == ST_DONE);

    console_period_cnt #(
        .CNT_W   (CNT_W),
        .DIV_RST (c_div_rst)
    ) u_period_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_run      (w_run),
        .i_track    (w_track),
        .i_div_next (w_div_next),
        .o_wrap     (w_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_fs       <= 1'b0;
            r_busy     <= 1'b0;
            r_miss     <= 1'b0;
            r_miss_cnt <= '0;
            r_ack      <= '0;
            r_rate     <= RATE_DEFAULT;
        end else begin
            r_miss <= 1'b0;
            if (w_track || w_wrap) begin
                r_rate <= w_code_req;
            end
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.fs_en) begin
                        r_state <= ST_WORK;
                        r_busy  <= 1'b1;
                    end
                end
                ST_WORK: begin
                    if (!bus.fs_en) begin
                        r_state <= ST_WAIT;
                        r_busy  <= 1'b0;
                    end else if (w_wrap) begin
                        r_state <= ST_DONE;
                        r_fs    <= 1'b1;
                        r_ack   <= '0;
                    end
                end
                ST_DONE: begin
                    r_ack <= r_ack + 1'b1;
                    // fd takes priority over a timeout landing in the same cycle
                    if (bus.fd) begin
                        r_state <= ST_WORK;
                        r_fs    <= 1'b0;
                    end else if (r_ack == c_ack_last) begin
                        r_state <= ST_WORK;
                        r_fs    <= 1'b0;
                        r_miss  <= 1'b1;
                        if (r_miss_cnt != '1) begin
                            r_miss_cnt <= r_miss_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.fs       = r_fs;
    assign bus.busy     = r_busy;
    assign bus.miss     = r_miss;
    assign bus.miss_cnt = r_miss_cnt;
    assign bus.rate_cur = r_rate;

endmodule

`default_nettype wire
